// File: rtl/mcc_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: FSM states, ALU ops,
// datapath select codes and base opcodes.
package mcc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_B   = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_4   = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_IMMEXT    = 2'b11;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  function automatic logic [2:0] imm_src(input logic [6:0] op);
    case (op)
      OP_STORE:          imm_src = IMM_S;
      OP_BRANCH:         imm_src = IMM_B;
      OP_JAL:            imm_src = IMM_J;
      OP_LUI, OP_AUIPC:  imm_src = IMM_U;
      default:           imm_src = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mcc_branch_cond.sv
// Branch-condition evaluation from funct3 and the flags of the BRANCH-cycle SUB.
// carry = 1 means the subtraction did not borrow (rs1 >= rs2 unsigned).
module mcc_branch_cond (
  input  logic [2:0] i_funct3,
  input  logic       i_zero,
  input  logic       i_neg,
  input  logic       i_carry,
  input  logic       i_ovf,
  output logic       o_taken
);

  always_comb begin
    o_taken = 1'b0;
    case (i_funct3)
      3'b000:  o_taken = i_zero;
      3'b001:  o_taken = ~i_zero;
      3'b100:  o_taken = i_neg ^ i_ovf;
      3'b101:  o_taken = ~(i_neg ^ i_ovf);
      3'b110:  o_taken = ~i_carry;
      3'b111:  o_taken = i_carry;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/rv32i_mc_controller.sv
// Main control FSM, ALU decoder and branch logic for the multi-cycle RV32I datapath.
// Define MCC_MEM_STALL_EN to hold FETCH/MEMREAD/MEMWRITE until mem_ready.
module rv32i_mc_controller
  import mcc_pkg::*;
#(
  parameter int ALUCTRL_W = 4,
  parameter int STATE_W   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic                 zero,
  input  logic                 neg,
  input  logic                 carry,
  input  logic                 ovf,
  input  logic                 mem_ready,
  output logic [2:0]           ImmSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic                 AddrSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic                 MemWrite,
  output logic                 PCWrite,
  output logic                 illegal_instr,
  output logic [STATE_W-1:0]   state
);

  state_t     r_state, w_next_state;
  aluop_t     w_alu_op;
  logic [3:0] w_alu_code;
  logic       w_ready, w_taken;
  logic       w_irwrite, w_regwrite, w_memwrite, w_pc_update, w_branch, w_illegal;
  logic [5:0] w_unused_funct7;

  assign w_unused_funct7 = {funct7[6], funct7[4:0]};

`ifdef MCC_MEM_STALL_EN
  assign w_ready = mem_ready;
`else
  logic w_unused_mem_ready;
  assign w_unused_mem_ready = mem_ready;
  assign w_ready = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = S_FETCH;
    ALUSrcA      = SRCA_PC;
    ALUSrcB      = SRCB_B;
    ResultSrc    = RES_ALUOUT;
    AddrSrc      = 1'b0;
    w_alu_op     = ALUOP_ADD;
    w_irwrite    = 1'b0;
    w_regwrite   = 1'b0;
    w_memwrite   = 1'b0;
    w_pc_update  = 1'b0;
    w_branch     = 1'b0;
    w_illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        ALUSrcB      = SRCB_4;
        ResultSrc    = RES_ALURESULT;
        w_irwrite    = w_ready;
        w_pc_update  = w_ready;
        w_next_state = w_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
          OP_RTYPE:          w_next_state = S_EXECR;
          OP_ITYPE:          w_next_state = S_EXECI;
          OP_BRANCH:         w_next_state = S_BRANCH;
          OP_JAL:            w_next_state = S_JAL;
          OP_JALR:           w_next_state = S_JALR;
          OP_LUI:            w_next_state = S_LUI;
          OP_AUIPC:          w_next_state = S_AUIPC;
          default:           w_illegal    = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA      = SRCA_A;
        ALUSrcB      = SRCB_IMM;
        w_next_state = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AddrSrc      = 1'b1;
        w_next_state = w_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc  = RES_DATA;
        w_regwrite = 1'b1;
      end
      S_MEMWRITE: begin
        AddrSrc      = 1'b1;
        w_memwrite   = 1'b1;
        w_next_state = w_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        ALUSrcA      = SRCA_A;
        w_alu_op     = ALUOP_FUNCT;
        w_next_state = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA      = SRCA_A;
        ALUSrcB      = SRCB_IMM;
        w_alu_op     = ALUOP_FUNCT;
        w_next_state = S_ALUWB;
      end
      S_ALUWB: w_regwrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA  = SRCA_A;
        w_alu_op = ALUOP_SUB;
        w_branch = 1'b1;
      end
      S_JALR: begin
        ALUSrcA      = SRCA_A;
        ALUSrcB      = SRCB_IMM;
        w_next_state = S_JAL;
      end
      S_JAL: begin
        // ALUOut still holds the target; this cycle computes the link value.
        ALUSrcA      = SRCA_OLDPC;
        ALUSrcB      = SRCB_4;
        w_pc_update  = 1'b1;
        w_next_state = S_ALUWB;
      end
      S_LUI: begin
        ResultSrc  = RES_IMMEXT;
        w_regwrite = 1'b1;
      end
      S_AUIPC: begin
        ALUSrcA      = SRCA_OLDPC;
        ALUSrcB      = SRCB_IMM;
        w_next_state = S_ALUWB;
      end
      default: w_next_state = S_FETCH;
    endcase
  end

  always_comb begin
    w_alu_code = ALU_ADD;
    case (w_alu_op)
      ALUOP_SUB: w_alu_code = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  w_alu_code = (op[5] & funct7[5]) ? ALU_SUB : ALU_ADD;
          3'b001:  w_alu_code = ALU_SLL;
          3'b010:  w_alu_code = ALU_SLT;
          3'b011:  w_alu_code = ALU_SLTU;
          3'b100:  w_alu_code = ALU_XOR;
          3'b101:  w_alu_code = funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110:  w_alu_code = ALU_OR;
          default: w_alu_code = ALU_AND;
        endcase
      end
      default: w_alu_code = ALU_ADD;
    endcase
  end

  mcc_branch_cond u_branch_cond (
    .i_funct3 (funct3),
    .i_zero   (zero),
    .i_neg    (neg),
    .i_carry  (carry),
    .i_ovf    (ovf),
    .o_taken  (w_taken)
  );

  // Reset masks every write enable even though the state already reads FETCH.
  assign IRWrite       = w_irwrite  & ~reset;
  assign RegWrite      = w_regwrite & ~reset;
  assign MemWrite      = w_memwrite & ~reset;
  assign PCWrite       = (w_pc_update | (w_branch & w_taken)) & ~reset;
  assign illegal_instr = w_illegal  & ~reset;
  assign ImmSrc        = imm_src(op);
  assign ALUControl    = ALUCTRL_W'(w_alu_code);
  assign state         = STATE_W'(r_state);

endmodule
